// File: rtl/instr_prefetch_unit_pkg.sv
// Shared types and sizing helpers for the instruction prefetch unit.
package prefetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned BYTE_W = 8;

    // PC increment in bytes for one instruction word.
    function automatic int unsigned step_of(input int unsigned instr_width);
        return instr_width / BYTE_W;
    endfunction

    // Width able to hold the values 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_prefetch_unit_if.sv
// Fetch-side bundle: memory request/response, redirect, and decode-facing output.
interface instr_prefetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   resp_valid;
    logic [INSTR_WIDTH-1:0] resp_data;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_addr;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic [ADDR_WIDTH-1:0]  out_pc_next;
    logic                   protocol_err;

    modport master (
        output req_valid, req_addr, out_valid, out_instr, out_pc, out_pc_next, protocol_err,
        input  req_ready, resp_valid, resp_data, redirect_valid, redirect_addr, out_ready
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_instr, out_pc, out_pc_next, protocol_err,
        output req_ready, resp_valid, resp_data, redirect_valid, redirect_addr, out_ready
    );
endinterface

// File: rtl/instr_prefetch_unit_fifo.sv
// Synchronous FIFO holding {pc, instr} entries; clear wins over push/pop.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Latency-tolerant fetch stage: credit-limited sequential reads, in-order response queue,
// redirect flush that discards responses still in flight.
module instr_prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_prefetch_unit_if.master bus
);
    localparam int unsigned           CW      = cnt_width(DEPTH);
    localparam int unsigned           EW      = ADDR_WIDTH + INSTR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(step_of(INSTR_WIDTH));

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic                  perr_q, perr_d;

    logic                  issue, accept, resp_ok, credit_ok;
    logic                  push, pop, clear;
    logic [EW-1:0]         head;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;

    // Queued plus outstanding words never exceed DEPTH, so every response has a slot.
    assign credit_ok = !fifo_full &&
                       (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH));
    assign accept    = issue && bus.req_ready;
    assign resp_ok   = bus.resp_valid && (inflight_q != '0);
    assign head_pc   = head[EW-1:INSTR_WIDTH];

    prefetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .wdata_i ({resp_pc_q, bus.resp_data}),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        perr_d     = perr_q | (bus.resp_valid && (inflight_q == '0));
        issue      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                if (bus.redirect_valid) begin
                    fetch_pc_d = bus.redirect_addr;
                    resp_pc_d  = bus.redirect_addr;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    // A response landing in the redirect cycle belongs to the old path.
                    clear      = 1'b1;
                    fetch_pc_d = bus.redirect_addr;
                    resp_pc_d  = bus.redirect_addr;
                    inflight_d = inflight_q - CW'(resp_ok);
                    drop_d     = inflight_d;
                    state_d    = (inflight_d != '0) ? FLUSH : RUN;
                end else begin
                    issue      = credit_ok;
                    push       = resp_ok;
                    pop        = !fifo_empty && bus.out_ready;
                    inflight_d = inflight_q + CW'(accept) - CW'(resp_ok);
                    if (accept)  fetch_pc_d = fetch_pc_q + PC_STEP;
                    if (resp_ok) resp_pc_d  = resp_pc_q + PC_STEP;
                end
            end
            FLUSH: begin
                if (bus.redirect_valid) begin
                    clear      = 1'b1;
                    fetch_pc_d = bus.redirect_addr;
                    resp_pc_d  = bus.redirect_addr;
                end
                if (resp_ok) begin
                    inflight_d = inflight_q - CW'(1);
                    drop_d     = drop_q - CW'(1);
                end
                if (drop_d == '0) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            perr_q     <= perr_d;
        end
    end

    // Outputs read as zero whenever nothing is offered, including throughout reset.
    assign bus.req_valid    = issue;
    assign bus.req_addr     = issue ? fetch_pc_q : '0;
    assign bus.out_valid    = !fifo_empty;
    assign bus.out_instr    = fifo_empty ? '0 : head[INSTR_WIDTH-1:0];
    assign bus.out_pc       = fifo_empty ? '0 : head_pc;
    assign bus.out_pc_next  = fifo_empty ? '0 : head_pc + PC_STEP;
    assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: in-order memory model with programmable latency,
// plus a second instance booting near the top of the address space.
module tb_instr_prefetch_unit;

    localparam logic [31:0] K = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_prefetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();
    instr_prefetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bw ();

    instr_prefetch_unit #(
        .ADDR_WIDTH (32), .INSTR_WIDTH (32), .DEPTH (4), .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    instr_prefetch_unit #(
        .ADDR_WIDTH (32), .INSTR_WIDTH (32), .DEPTH (4), .RESET_PC (32'hFFFF_FFF8)
    ) dut_w (
        .clk (clk), .rst (rst), .bus (bw)
    );

    int unsigned n_chk;
    int unsigned n_pass;
    int unsigned cyc;
    int unsigned lat;
    int unsigned n_acc;
    int unsigned due_q[$];
    logic [31:0] addr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_model();
        due_q.delete();
        addr_q.delete();
        cyc            = 0;
        n_acc          = 0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
    endtask

    // One clock: record accepts late in the cycle, then present due responses after the edge.
    task automatic tick();
        logic        acc, wacc;
        logic [31:0] a, wa;
        #2;
        acc  = bus.req_valid && bus.req_ready;
        a    = bus.req_addr;
        wacc = bw.req_valid && bw.req_ready;
        wa   = bw.req_addr;
        if (acc) begin
            due_q.push_back(cyc + lat);
            addr_q.push_back(a);
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = addr_q[0] ^ K;
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            bus.resp_valid = 1'b0;
            bus.resp_data  = '0;
        end
        bw.resp_valid = wacc;
        bw.resp_data  = wa ^ K;
    endtask

    initial begin
        rst                = 1'b1;
        lat                = 1;
        bus.req_ready      = 1'b1;
        bus.resp_valid     = 1'b0;
        bus.resp_data      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.out_ready      = 1'b1;
        bw.req_ready       = 1'b1;
        bw.resp_valid      = 1'b0;
        bw.resp_data       = '0;
        bw.redirect_valid  = 1'b0;
        bw.redirect_addr   = '0;
        bw.out_ready       = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_req_addr",  bus.req_addr, 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pc",    bus.out_pc, 32'd0);
        check("rst_perr",      32'(bus.protocol_err), 32'd0);
        check("rst_w_req_addr", bw.req_addr, 32'd0);
        clear_model();
        rst = 1'b0;
        #1;
        check("boot_req_valid", 32'(bus.req_valid), 32'd0);

        // Sequential streaming, latency 1
        tick();
        check("t1_r0_req_valid", 32'(bus.req_valid), 32'd1);
        check("t1_r0_req_addr",  bus.req_addr, 32'h0);
        check("t4_r0_req_addr",  bw.req_addr, 32'hFFFF_FFF8);
        tick();
        check("t1_r1_req_addr",  bus.req_addr, 32'h4);
        check("t1_r1_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t1_r2_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_r2_out_pc",    bus.out_pc, 32'h0);
        check("t1_r2_pc_next",   bus.out_pc_next, 32'h4);
        check("t1_r2_instr",     bus.out_instr, 32'h0 ^ K);
        check("t1_r2_req_addr",  bus.req_addr, 32'h8);
        check("t4_r2_out_pc",    bw.out_pc, 32'hFFFF_FFF8);
        check("t4_r2_pc_next",   bw.out_pc_next, 32'hFFFF_FFFC);
        check("t4_r2_req_addr",  bw.req_addr, 32'h0);
        tick();
        check("t1_r3_out_pc",    bus.out_pc, 32'h4);
        check("t1_r3_pc_next",   bus.out_pc_next, 32'h8);
        check("t4_r3_out_pc",    bw.out_pc, 32'hFFFF_FFFC);
        check("t4_r3_pc_next",   bw.out_pc_next, 32'h0);
        tick();
        check("t1_r4_out_pc",    bus.out_pc, 32'h8);
        check("t1_r4_pc_next",   bus.out_pc_next, 32'hC);
        check("t4_r4_out_pc",    bw.out_pc, 32'h0);
        check("t4_r4_instr",     bw.out_instr, 32'h0 ^ K);

        // Decode stall: credits run out, head held
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_out_valid", 32'(bus.out_valid), 32'd1);
            check("t2_out_pc",    bus.out_pc, 32'h8);
            check("t2_instr",     bus.out_instr, 32'h8 ^ K);
            if (i >= 1) check("t2_req_valid", 32'(bus.req_valid), 32'd0);
        end
        check("t2_accepts", n_acc, 32'd6);

        // Redirect coinciding with a head handshake on a full queue
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h200;
        #1;
        check("t5_redir_req_valid", 32'(bus.req_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("t5_r15_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_r15_req_addr",  bus.req_addr, 32'h200);
        tick();
        check("t5_r16_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t5_r17_out_pc",    bus.out_pc, 32'h200);
        check("t5_r17_pc_next",   bus.out_pc_next, 32'h204);
        check("t5_r17_instr",     bus.out_instr, 32'h200 ^ K);
        tick();
        check("t5_r18_out_pc",    bus.out_pc, 32'h204);

        // Latency 3, redirect with two reads outstanding
        rst = 1'b1;
        clear_model();
        tick();
        tick();
        clear_model();
        lat = 3;
        rst = 1'b0;
        tick();
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h100;
        #1;
        check("t3_redir_req_valid", 32'(bus.req_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("t3_r3_req_valid", 32'(bus.req_valid), 32'd0);
        check("t3_r3_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t3_r4_req_valid", 32'(bus.req_valid), 32'd0);
        tick();
        check("t3_r5_req_valid", 32'(bus.req_valid), 32'd1);
        check("t3_r5_req_addr",  bus.req_addr, 32'h100);
        tick();
        tick();
        tick();
        check("t3_r8_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t3_r9_out_valid", 32'(bus.out_valid), 32'd1);
        check("t3_r9_out_pc",    bus.out_pc, 32'h100);
        check("t3_r9_pc_next",   bus.out_pc_next, 32'h104);
        check("t3_r9_instr",     bus.out_instr, 32'h100 ^ K);
        tick();
        check("t3_r10_out_pc",   bus.out_pc, 32'h104);

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        check("t6_rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("t6_rst_req_addr",  bus.req_addr, 32'd0);
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_out_pc",    bus.out_pc, 32'd0);
        check("t6_rst_pc_next",   bus.out_pc_next, 32'd0);
        check("t6_rst_instr",     bus.out_instr, 32'd0);
        clear_model();
        tick();
        tick();
        clear_model();
        lat = 1;
        rst = 1'b0;

        // Stray response with nothing in flight
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h1234_5678;
        tick();
        check("t6_r0_perr",      32'(bus.protocol_err), 32'd1);
        check("t6_r0_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_r0_req_addr",  bus.req_addr, 32'h0);
        tick();
        check("t6_r1_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t6_r2_out_pc",    bus.out_pc, 32'h0);
        check("t6_r2_instr",     bus.out_instr, 32'h0 ^ K);
        check("t6_r2_perr",      32'(bus.protocol_err), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_final_perr",      32'(bus.protocol_err), 32'd0);
        check("t6_final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
